fetch_pc: RTL and testbench

FETCH_PC -- requirements
Module: fetch_pc

---
 rtl/fetch_pc_pkg.sv | 27 ++
 rtl/fetch_pc_if.sv | 43 ++++
 rtl/fetch_pc.sv | 147 ++++++++++++++
 tb/tb_fetch_pc.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pc_pkg.sv
// fetch_pc_pkg -- shared definitions for the instruction-fetch PC stage.
//   ADDR_W / INST_W : address and instruction bus widths
//   OPC_JAL / OPC_BRANCH : RV32 major opcodes that the fetch stage redirects on
//   NOP_INST        : canonical ADDI x0,x0,0 encoding
//   slot_t          : contents of the registered fetch slot handed to decode
package fetch_pc_pkg;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

  // Fetch address step for sequential flow.
  localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;
  } slot_t;

endpackage

// File: rtl/fetch_pc_if.sv
// fetch_pc_if -- bundles the fetch stage's icache, predictor and decode signals.
//   icache : if_req_o/if_addr_o out, icache_hit_i/icache_inst_i in
//   pred   : pre_raddr_o out, pre_taken_i in (same-cycle lookup)
//   decode : if_valid_o, if_pc_o, if_inst_o, if_pred_taken_o, if_pred_target_o out;
//            stall_i in
//   redirect : flush_i, flush_pc_i in
// master = fetch stage, slave = the surrounding icache/predictor/decode/EX.
interface fetch_pc_if;
  import fetch_pc_pkg::*;

  logic              if_req_o;
  logic [ADDR_W-1:0] if_addr_o;
  logic              icache_hit_i;
  logic [INST_W-1:0] icache_inst_i;

  logic [ADDR_W-1:0] pre_raddr_o;
  logic              pre_taken_i;

  logic              if_valid_o;
  logic [ADDR_W-1:0] if_pc_o;
  logic [INST_W-1:0] if_inst_o;
  logic              if_pred_taken_o;
  logic [ADDR_W-1:0] if_pred_target_o;

  logic              stall_i;
  logic              flush_i;
  logic [ADDR_W-1:0] flush_pc_i;

  modport master (
    output if_req_o, if_addr_o, pre_raddr_o,
    output if_valid_o, if_pc_o, if_inst_o, if_pred_taken_o, if_pred_target_o,
    input  icache_hit_i, icache_inst_i, pre_taken_i,
    input  stall_i, flush_i, flush_pc_i
  );

  modport slave (
    input  if_req_o, if_addr_o, pre_raddr_o,
    input  if_valid_o, if_pc_o, if_inst_o, if_pred_taken_o, if_pred_target_o,
    output icache_hit_i, icache_inst_i, pre_taken_i,
    output stall_i, flush_i, flush_pc_i
  );

endinterface

// File: rtl/fetch_pc.sv
// fetch_pc -- instruction fetch PC generator with a single-entry fetch slot.
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset (wins over rdy and flush)
//   rdy  : global ready; low freezes every register
//   bus  : fetch_pc_if.master -- icache request/response, predictor lookup,
//          registered fetch slot to decode, stall and EX redirect.
// One icache request is in flight at most. A redirect that lands while a
// request is outstanding parks the FSM in DRAIN until that stale response
// returns, so it can never be mistaken for the redirect target's word.
module fetch_pc
  import fetch_pc_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      rdy,
  fetch_pc_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic              req_q;
  slot_t             slot_q;

  // ---------------------------------------------------------------------------
  // Next-PC / prediction from the returning instruction word
  // ---------------------------------------------------------------------------
  logic [6:0]        opcode;
  logic [ADDR_W-1:0] imm_j;
  logic [ADDR_W-1:0] imm_b;
  logic [ADDR_W-1:0] next_pc;
  logic              pred_taken;
  logic [ADDR_W-1:0] flush_tgt;
  logic              consume;

  always_comb begin
    opcode = bus.icache_inst_i[6:0];
    imm_j  = {{11{bus.icache_inst_i[31]}}, bus.icache_inst_i[31],
              bus.icache_inst_i[19:12], bus.icache_inst_i[20],
              bus.icache_inst_i[30:21], 1'b0};
    imm_b  = {{19{bus.icache_inst_i[31]}}, bus.icache_inst_i[31],
              bus.icache_inst_i[7], bus.icache_inst_i[30:25],
              bus.icache_inst_i[11:8], 1'b0};

    // JALR target depends on a register value, so it falls through to +4.
    next_pc    = pc_q + PC_STEP;
    pred_taken = 1'b0;
    if (opcode == OPC_JAL) begin
      next_pc    = pc_q + imm_j;
      pred_taken = 1'b1;
    end else if (opcode == OPC_BRANCH && bus.pre_taken_i) begin
      next_pc    = pc_q + imm_b;
      pred_taken = 1'b1;
    end
  end

  // Redirect targets are word aligned; low bits from EX are ignored.
  assign flush_tgt = bus.flush_pc_i & ~32'h0000_0003;
  assign consume   = slot_q.valid & ~bus.stall_i;

  // ---------------------------------------------------------------------------
  // FSM + PC + fetch slot
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= S_IDLE;
      pc_q               <= '0;
      req_q              <= 1'b0;
      slot_q.valid       <= 1'b0;
      slot_q.pc          <= '0;
      slot_q.inst        <= '0;
      slot_q.pred_taken  <= 1'b0;
      slot_q.pred_target <= '0;
    end else if (rdy) begin
      // Default: a consumed slot empties; a capture below overrides this.
      if (consume)
        slot_q.valid <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (bus.flush_i) begin
            pc_q         <= flush_tgt;
            slot_q.valid <= 1'b0;
          end else if (!slot_q.valid || !bus.stall_i) begin
            // Only fetch when the slot will be free to receive the word.
            state_q <= S_REQ;
            req_q   <= 1'b1;
          end
        end

        S_REQ: begin
          if (bus.flush_i) begin
            pc_q         <= flush_tgt;
            slot_q.valid <= 1'b0;
            // A response in the flush cycle is retired right here; otherwise
            // the outstanding one is still coming and must be swallowed.
            state_q      <= bus.icache_hit_i ? S_REQ : S_DRAIN;
          end else if (bus.icache_hit_i) begin
            slot_q.valid       <= 1'b1;
            slot_q.pc          <= pc_q;
            slot_q.inst        <= bus.icache_inst_i;
            slot_q.pred_taken  <= pred_taken;
            slot_q.pred_target <= next_pc;
            pc_q               <= next_pc;
            state_q            <= S_IDLE;
            req_q              <= 1'b0;
          end
        end

        S_DRAIN: begin
          // if_addr_o still shows pc_q here; the icache only cares about the
          // address it latched at request time, so pc_q may already hold the
          // redirect target.
          if (bus.flush_i) begin
            pc_q         <= flush_tgt;
            slot_q.valid <= 1'b0;
          end
          if (bus.icache_hit_i)
            state_q <= S_REQ;
        end

        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.if_req_o         = req_q;
  assign bus.if_addr_o        = pc_q;
  assign bus.pre_raddr_o      = pc_q;
  assign bus.if_valid_o       = slot_q.valid;
  assign bus.if_pc_o          = slot_q.pc;
  assign bus.if_inst_o        = slot_q.inst;
  assign bus.if_pred_taken_o  = slot_q.pred_taken;
  assign bus.if_pred_target_o = slot_q.pred_target;

endmodule

// File: tb/tb_fetch_pc.sv
// tb_fetch_pc -- scoreboard bench for fetch_pc.
// An icache model answers each request after `lat` cycles and logs request
// addresses; expected decode slots are queued by the stimulus and popped as
// decode consumes them.
module tb_fetch_pc;
  import fetch_pc_pkg::*;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        taken;
    logic [31:0] tgt;
  } exp_t;

  logic clk, rst, rdy;
  logic pred_en;
  int   lat;
  int   n_chk, n_err;

  exp_t        sb[$];
  logic [31:0] req_log[$];
  logic [31:0] mem[logic [31:0]];

  fetch_pc_if bus();

  fetch_pc dut (.clk(clk), .rst(rst), .rdy(rdy), .bus(bus.master));

  assign bus.pre_taken_i = pred_en;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : NOP_INST;
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm);
    return {imm[12], imm[10:5], 5'd2, 5'd1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  task automatic push(input logic [31:0] pc, input logic [31:0] inst,
                      input logic taken, input logic [31:0] tgt);
    exp_t e;
    e.pc = pc; e.inst = inst; e.taken = taken; e.tgt = tgt;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 40 && !bus.if_valid_o; i++) tick();
    chk(tag, 32'(bus.if_valid_o), 32'd1);
  endtask

  // icache model: one request at a time, response `lat` cycles after it is seen.
  initial begin : icache
    int          cnt;
    logic        busy;
    logic [31:0] addr;
    busy = 1'b0; cnt = 0; addr = '0;
    bus.icache_hit_i  = 1'b0;
    bus.icache_inst_i = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.icache_hit_i = 1'b0;
      if (busy) begin
        cnt--;
        if (cnt == 0) begin
          bus.icache_hit_i  = 1'b1;
          bus.icache_inst_i = rd(addr);
          busy              = 1'b0;
        end
      end else if (!rst && bus.if_req_o) begin
        busy = 1'b1;
        addr = bus.if_addr_o;
        cnt  = lat;
        req_log.push_back(addr);
      end
    end
  end

  // Decode-side monitor: every consumed slot must match the scoreboard head.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && rdy && bus.if_valid_o && !bus.stall_i) begin
        if (sb.size() == 0) begin
          chk("slot_unexpected_pc", bus.if_pc_o, 32'hDEAD_BEEF);
        end else begin
          e = sb.pop_front();
          chk("slot_pc",     bus.if_pc_o,               e.pc);
          chk("slot_inst",   bus.if_inst_o,             e.inst);
          chk("slot_taken",  32'(bus.if_pred_taken_o),  32'(e.taken));
          chk("slot_target", bus.if_pred_target_o,      e.tgt);
          if (e.pc == 32'h40 && e.taken) pred_en = 1'b0;
        end
      end
    end
  end

  initial begin : main
    logic [31:0] exp_req[$];
    int          n0;
    logic        saw_valid;
    logic [31:0] jal, beq, jalr;

    n_chk = 0; n_err = 0;
    rst = 1'b1; rdy = 1'b1; pred_en = 1'b1; lat = 1;
    bus.stall_i = 1'b0; bus.flush_i = 1'b0; bus.flush_pc_i = '0;

    jal  = enc_j(21'h00020);
    beq  = enc_b(13'h1FF8);
    jalr = 32'h0000_80E7;
    mem[32'h10] = jal;
    mem[32'h40] = beq;
    mem[32'h44] = jalr;

    // Sequential run, JAL, taken then not-taken BEQ, JALR falls through.
    push(32'h00, NOP_INST, 1'b0, 32'h04);
    push(32'h04, NOP_INST, 1'b0, 32'h08);
    push(32'h08, NOP_INST, 1'b0, 32'h0C);
    push(32'h0C, NOP_INST, 1'b0, 32'h10);
    push(32'h10, jal,      1'b1, 32'h30);
    push(32'h30, NOP_INST, 1'b0, 32'h34);
    push(32'h34, NOP_INST, 1'b0, 32'h38);
    push(32'h38, NOP_INST, 1'b0, 32'h3C);
    push(32'h3C, NOP_INST, 1'b0, 32'h40);
    push(32'h40, beq,      1'b1, 32'h38);
    push(32'h38, NOP_INST, 1'b0, 32'h3C);
    push(32'h3C, NOP_INST, 1'b0, 32'h40);
    push(32'h40, beq,      1'b0, 32'h44);
    push(32'h44, jalr,     1'b0, 32'h48);
    exp_req = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h30, 32'h34, 32'h38,
                32'h3C, 32'h40, 32'h38, 32'h3C, 32'h40, 32'h44, 32'h48};

    repeat (3) tick();
    chk("rst_valid",  32'(bus.if_valid_o),      32'd0);
    chk("rst_req",    32'(bus.if_req_o),        32'd0);
    chk("rst_pc",     bus.if_pc_o,              32'd0);
    chk("rst_inst",   bus.if_inst_o,            32'd0);
    chk("rst_taken",  32'(bus.if_pred_taken_o), 32'd0);
    chk("rst_target", bus.if_pred_target_o,     32'd0);
    chk("rst_raddr",  bus.pre_raddr_o,          32'd0);

    rst = 1'b0;
    tick();
    chk("first_req",  32'(bus.if_req_o), 32'd1);
    chk("first_addr", bus.if_addr_o,     32'd0);

    for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
    chk("seq_drained", 32'(sb.size()), 32'd0);
    bus.stall_i = 1'b1;
    wait_valid("park_48");
    chk("req_log_len", 32'(req_log.size()), 32'(exp_req.size()));
    for (int i = 0; i < exp_req.size() && i < req_log.size(); i++)
      chk($sformatf("req_addr[%0d]", i), req_log[i], exp_req[i]);

    // Stall: slot frozen, no request, resumes once stall drops.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_req",   32'(bus.if_req_o),   32'd0);
      chk("stall_valid", 32'(bus.if_valid_o), 32'd1);
      chk("stall_pc",    bus.if_pc_o,         32'h48);
      chk("stall_inst",  bus.if_inst_o,       NOP_INST);
    end
    push(32'h48, NOP_INST, 1'b0, 32'h4C);
    bus.stall_i = 1'b0;
    tick();
    chk("resume_req",  32'(bus.if_req_o), 32'd1);
    chk("resume_addr", bus.if_addr_o,     32'h4C);
    bus.stall_i = 1'b1;
    wait_valid("park_4c");
    chk("park_4c_pc", bus.if_pc_o, 32'h4C);

    // Flush in IDLE, then flush coincident with a hit.
    n0 = req_log.size();
    bus.flush_i = 1'b1; bus.flush_pc_i = 32'h200;
    tick();
    bus.flush_i = 1'b0;
    chk("fl_idle_valid", 32'(bus.if_valid_o), 32'd0);
    chk("fl_idle_raddr", bus.pre_raddr_o,     32'h200);
    tick();
    chk("fl_idle_req",  32'(bus.if_req_o), 32'd1);
    chk("fl_idle_addr", bus.if_addr_o,     32'h200);
    for (int i = 0; i < 10 && !bus.icache_hit_i; i++) tick();
    bus.flush_i = 1'b1; bus.flush_pc_i = 32'h103;
    tick();
    bus.flush_i = 1'b0;
    chk("fl_hit_valid", 32'(bus.if_valid_o), 32'd0);
    chk("fl_hit_req",   32'(bus.if_req_o),   32'd1);
    chk("fl_hit_addr",  bus.if_addr_o,       32'h100);
    chk("fl_hit_nreq",  32'(req_log.size()), 32'(n0 + 2));
    if (req_log.size() == n0 + 2) chk("fl_hit_log", req_log[n0+1], 32'h100);
    wait_valid("park_100a");
    chk("park_100a_pc",  bus.if_pc_o,            32'h100);
    chk("park_100a_tgt", bus.if_pred_target_o,   32'h104);

    // Flush while a slow request is outstanding: stale word must be drained.
    lat = 3;
    n0  = req_log.size();
    bus.flush_i = 1'b1; bus.flush_pc_i = 32'h20;
    tick();
    bus.flush_i = 1'b0;
    chk("fl_pend_clear", 32'(bus.if_valid_o), 32'd0);
    tick();
    chk("fl_pend_req",  32'(bus.if_req_o), 32'd1);
    chk("fl_pend_addr", bus.if_addr_o,     32'h20);
    bus.flush_i = 1'b1; bus.flush_pc_i = 32'h103;
    tick();
    bus.flush_i = 1'b0;
    chk("drain_req",   32'(bus.if_req_o), 32'd1);
    chk("drain_raddr", bus.pre_raddr_o,   32'h100);
    saw_valid = bus.if_valid_o;
    for (int i = 0; i < 12 && req_log.size() < n0 + 2; i++) begin
      tick();
      saw_valid |= bus.if_valid_o;
    end
    chk("drain_no_slot", 32'(saw_valid),      32'd0);
    chk("drain_nreq",    32'(req_log.size()), 32'(n0 + 2));
    if (req_log.size() == n0 + 2) begin
      chk("drain_log0", req_log[n0],   32'h20);
      chk("drain_log1", req_log[n0+1], 32'h100);
    end
    wait_valid("park_100b");
    chk("park_100b_pc",   bus.if_pc_o,       32'h100);
    chk("park_100b_inst", bus.if_inst_o,     NOP_INST);
    chk("park_100b_pc_q", bus.pre_raddr_o,   32'h104);

    // rdy low: flush and stall release are both ignored.
    rdy = 1'b0;
    bus.flush_i = 1'b1; bus.flush_pc_i = 32'h300;
    bus.stall_i = 1'b0;
    tick();
    tick();
    chk("rdy_valid", 32'(bus.if_valid_o), 32'd1);
    chk("rdy_pc",    bus.if_pc_o,         32'h100);
    chk("rdy_pc_q",  bus.pre_raddr_o,     32'h104);
    chk("rdy_req",   32'(bus.if_req_o),   32'd0);
    bus.stall_i = 1'b1;
    bus.flush_i = 1'b0;
    rdy = 1'b1;
    tick();
    chk("rdy_after_valid", 32'(bus.if_valid_o), 32'd1);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
